// File: rtl/multiplier_sequencer_pkg.sv
// Shared types and defaults for the shift-add multiplier sequencer.
package multiplier_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} mul_state_t;

   localparam int DEFAULT_N = 4;

endpackage

// File: rtl/multiplier_sequencer_if.sv
// Request/datapath handshake bundle between the sequencer and its neighbours.
interface multiplier_sequencer_if import multiplier_pkg::*; #(
   parameter int N = DEFAULT_N
);
   localparam int CW = $clog2(N + 1);

   logic          start;
   logic          ready;
   logic          abort;
   logic          mult_lsb;
   logic          mult_zero;
   logic          load;
   logic          add;
   logic          shift;
   logic          valid;
   logic          result_ready;
   logic [CW-1:0] count;
   logic          is_zero;

   modport slave (
      input  start, abort, mult_lsb, mult_zero, result_ready,
      output ready, load, add, shift, valid, count, is_zero
   );

   modport master (
      output start, abort, mult_lsb, mult_zero, result_ready,
      input  ready, load, add, shift, valid, count, is_zero
   );

endinterface

// File: rtl/multiplier_sequencer_counter.sv
// Iteration counter: presets to N, counts down to zero and never wraps.
module multiplier_counter_n import multiplier_pkg::*; #(
   parameter int N = DEFAULT_N
) (
   input  logic                      clock,
   input  logic                      n_reset,
   input  logic                      preset,
   input  logic                      dec,
   input  logic                      clear,
   output logic [$clog2(N+1)-1:0]    count,
   output logic                      is_zero
);
   localparam int CW = $clog2(N + 1);

   always_ff @(posedge clock) begin
      if (!n_reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (preset) begin
         count <= CW'(N);
      end else if (dec && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign is_zero = (count == '0);

endmodule

// File: rtl/multiplier_sequencer.sv
// Control FSM for the shift-add multiplier: sequences load, add/shift steps
// and the result handshake, with optional early exit on a zero multiplier.
module multiplier_sequencer import multiplier_pkg::*; #(
   parameter int N          = DEFAULT_N,
   parameter int EARLY_EXIT = 1
) (
   input  logic                  clock,
   input  logic                  n_reset,
   multiplier_sequencer_if.slave bus
);
   localparam int CW = $clog2(N + 1);

   mul_state_t    state;
   mul_state_t    nxt;
   logic          cnt_preset;
   logic          cnt_dec;
   logic          cnt_clear;
   logic [CW-1:0] count;
   logic          is_zero;
   logic          early_hit;
   logic          ready_d;
   logic          load_d;
   logic          add_d;
   logic          shift_d;
   logic          valid_d;

   multiplier_counter_n #(
      .N (N)
   ) u_counter (
      .clock   (clock),
      .n_reset (n_reset),
      .preset  (cnt_preset),
      .dec     (cnt_dec),
      .clear   (cnt_clear),
      .count   (count),
      .is_zero (is_zero)
   );

   assign early_hit = (EARLY_EXIT != 0) && bus.mult_zero;

   always_ff @(posedge clock) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt        = state;
      cnt_preset = 1'b0;
      cnt_dec    = 1'b0;
      cnt_clear  = 1'b0;
      ready_d    = (state == IDLE);
      load_d     = 1'b0;
      add_d      = 1'b0;
      shift_d    = 1'b0;
      valid_d    = 1'b0;

      // Abort overrides everything, including a start seen in IDLE.
      if (bus.abort) begin
         nxt       = IDLE;
         cnt_clear = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  nxt = LOAD;
               end
            end
            LOAD: begin
               load_d     = 1'b1;
               cnt_preset = 1'b1;
               nxt        = STEP;
            end
            STEP: begin
               if (early_hit) begin
                  cnt_clear = 1'b1;
                  nxt       = DONE;
               end else begin
                  shift_d = 1'b1;
                  add_d   = bus.mult_lsb;
                  cnt_dec = 1'b1;
                  // count<=1 also catches a corrupted zero count in STEP.
                  if (count <= CW'(1)) begin
                     nxt = DONE;
                  end
               end
            end
            DONE: begin
               valid_d = 1'b1;
               if (bus.result_ready) begin
                  nxt = IDLE;
               end
            end
            default: begin
               nxt       = IDLE;
               cnt_clear = 1'b1;
            end
         endcase
      end
   end

   assign bus.ready   = ready_d;
   assign bus.load    = load_d;
   assign bus.add     = add_d;
   assign bus.shift   = shift_d;
   assign bus.valid   = valid_d;
   assign bus.count   = count;
   assign bus.is_zero = is_zero;

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Bench for multiplier_sequencer: two instances (early exit on/off), each
// with a small datapath model and a queue of expected per-cycle outputs.
module tb_multiplier_sequencer;

   localparam int N = 4;

   typedef struct packed {
      bit         st;
      bit         ab;
      bit         rr;
      logic [8:0] exp;  // {ready,load,add,shift,valid,is_zero,count[2:0]}
   } ent_t;

   logic clock;
   logic n_reset;
   int   n_checks;
   int   n_pass;

   ent_t qa[$];
   ent_t qb[$];

   logic [3:0] op_a, op_b, mreg_a, mreg_b;

   multiplier_sequencer_if #(.N(N)) ifa ();
   multiplier_sequencer_if #(.N(N)) ifb ();

   multiplier_sequencer #(.N(N), .EARLY_EXIT(1)) dut_a (
      .clock   (clock),
      .n_reset (n_reset),
      .bus     (ifa)
   );

   multiplier_sequencer #(.N(N), .EARLY_EXIT(0)) dut_b (
      .clock   (clock),
      .n_reset (n_reset),
      .bus     (ifb)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Datapath multiplier registers that feed mult_lsb / mult_zero
   always @(posedge clock) begin
      if (!n_reset)       mreg_a <= 4'd0;
      else if (ifa.load)  mreg_a <= op_a;
      else if (ifa.shift) mreg_a <= mreg_a >> 1;
      if (!n_reset)       mreg_b <= 4'd0;
      else if (ifb.load)  mreg_b <= op_b;
      else if (ifb.shift) mreg_b <= mreg_b >> 1;
   end

   assign ifa.mult_lsb  = mreg_a[0];
   assign ifa.mult_zero = (mreg_a == 4'd0);
   assign ifb.mult_lsb  = mreg_b[0];
   assign ifb.mult_zero = (mreg_b == 4'd0);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s observed=%h expected=%h", tag, got, exp);
   endtask

   function automatic logic [8:0] mk(bit rdy, bit ld, bit ad, bit sh, bit vl, int cnt);
      logic [2:0] c;
      c = 3'(cnt);
      return {rdy, ld, ad, sh, vl, (c == 3'd0), c};
   endfunction

   function automatic ent_t ent(bit st, bit ab, bit rr, logic [8:0] e);
      ent_t r;
      r.st = st; r.ab = ab; r.rr = rr; r.exp = e;
      return r;
   endfunction

   function automatic logic [8:0] obs(bit sel);
      if (sel)
         return {ifb.ready, ifb.load, ifb.add, ifb.shift, ifb.valid, ifb.is_zero, ifb.count};
      return {ifa.ready, ifa.load, ifa.add, ifa.shift, ifa.valid, ifa.is_zero, ifa.count};
   endfunction

   task automatic push(input bit sel, input ent_t e);
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
   endtask

   task automatic drive(input bit sel, input ent_t e);
      if (sel) begin
         ifb.start = e.st; ifb.abort = e.ab; ifb.result_ready = e.rr;
      end else begin
         ifa.start = e.st; ifa.abort = e.ab; ifa.result_ready = e.rr;
      end
   endtask

   // Reference trace of one operation, starting with the IDLE cycle that issues start.
   task automatic build(input bit sel, input logic [3:0] operand, input bit ee,
                        input int hold, input bit st_done, input int abort_at);
      logic [3:0] m;
      int         cnt;
      if (sel) op_b = operand;
      else     op_a = operand;
      push(sel, ent(1, 0, 0, mk(1, 0, 0, 0, 0, 0)));
      push(sel, ent(0, 0, 0, mk(0, 1, 0, 0, 0, 0)));
      m   = operand;
      cnt = N;
      forever begin
         if (abort_at > 0 && cnt == abort_at) begin
            push(sel, ent(0, 1, 0, mk(0, 0, 0, 0, 0, cnt)));
            push(sel, ent(1, 1, 0, mk(1, 0, 0, 0, 0, 0)));
            push(sel, ent(0, 0, 0, mk(1, 0, 0, 0, 0, 0)));
            return;
         end
         if (ee && m == 4'd0) begin
            push(sel, ent(0, 0, 0, mk(0, 0, 0, 0, 0, cnt)));
            break;
         end
         push(sel, ent(0, 0, 0, mk(0, 0, m[0], 1, 0, cnt)));
         m   = m >> 1;
         cnt = cnt - 1;
         if (cnt == 0) break;
      end
      for (int i = 0; i <= hold; i++)
         push(sel, ent(st_done && (i < hold), 0, (i == hold), mk(0, 0, 0, 0, 1, 0)));
      push(sel, ent(0, 0, 0, mk(1, 0, 0, 0, 0, 0)));
   endtask

   task automatic run_queues(input string name);
      ent_t ea, eb, idle;
      idle = ent(0, 0, 0, mk(1, 0, 0, 0, 0, 0));
      for (int cyc = 0; cyc < 200 && (qa.size() > 0 || qb.size() > 0); cyc++) begin
         @(negedge clock);
         ea = (qa.size() > 0) ? qa.pop_front() : idle;
         eb = (qb.size() > 0) ? qb.pop_front() : idle;
         drive(0, ea);
         drive(1, eb);
         #1;
         chk($sformatf("%s.ee1.c%0d", name, cyc), 32'(obs(0)), 32'(ea.exp));
         chk($sformatf("%s.ee0.c%0d", name, cyc), 32'(obs(1)), 32'(eb.exp));
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_reset  = 1'b0;
      op_a = 4'd0; op_b = 4'd0;
      drive(0, ent(0, 0, 0, 9'd0));
      drive(1, ent(0, 0, 0, 9'd0));
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset.ee1", 32'(obs(0)), 32'(mk(1, 0, 0, 0, 0, 0)));
      chk("reset.ee0", 32'(obs(1)), 32'(mk(1, 0, 0, 0, 0, 0)));
      n_reset = 1'b1;

      build(0, 4'b1011, 1, 0, 0, 0);
      build(1, 4'b1011, 0, 0, 0, 0);
      run_queues("full");

      build(0, 4'b0010, 1, 0, 0, 0);
      build(1, 4'b0001, 0, 0, 0, 0);
      run_queues("early");

      build(0, 4'b1011, 1, 3, 1, 0);
      build(1, 4'b0000, 0, 3, 1, 0);
      run_queues("hold");

      build(0, 4'b1111, 1, 0, 0, 2);
      build(1, 4'b1111, 0, 0, 0, 2);
      run_queues("abort");

      build(0, 4'b0000, 1, 1, 0, 0);
      build(1, 4'b0110, 0, 0, 0, 0);
      run_queues("zero");

      // Reset mid-operation returns both instances to the power-on state.
      build(0, 4'b1101, 1, 0, 0, 0);
      build(1, 4'b1101, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         drive(0, qa.pop_front());
         drive(1, qb.pop_front());
      end
      qa.delete();
      qb.delete();
      n_reset = 1'b0;
      drive(0, ent(0, 0, 0, 9'd0));
      drive(1, ent(0, 0, 0, 9'd0));
      @(negedge clock);
      chk("midreset.ee1", 32'(obs(0)), 32'(mk(1, 0, 0, 0, 0, 0)));
      chk("midreset.ee0", 32'(obs(1)), 32'(mk(1, 0, 0, 0, 0, 0)));
      n_reset = 1'b1;

      build(0, 4'b0101, 1, 0, 0, 0);
      build(1, 4'b1000, 0, 0, 0, 0);
      run_queues("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
